// File: rtl/div_ctrl.sv
// Sequencing controller for the shared 64-bit iterative divider: formats operands, resolves
// divide-by-zero / signed overflow locally, launches the divider and returns tagged results.
// Optional result reuse for repeated operand sets is enabled with `define DIVCTL_REUSE_EN.
module div_ctrl #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_op_i,
    input  logic [63:0]      in_src1_i,
    input  logic [63:0]      in_src2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             div_req_valid_o,
    output logic             div_block_o,
    output logic [63:0]      div_op_1_o,
    output logic [63:0]      div_op_2_o,
    output logic             div_sign_op_1_o,
    output logic             div_sign_op_2_o,
    input  logic [63:0]      div_quotient_i,
    input  logic [63:0]      div_remainder_i,
    input  logic             div_ready_i,
    input  logic             div_valid_i
);

    localparam logic [63:0] MinNeg64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MinNeg32 = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] AllOnes  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             is_w_q, is_w_d;
    logic             sign_q, sign_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [63:0]      op1_q, op1_d;
    logic [63:0]      op2_q, op2_d;
    logic [63:0]      res_q, res_d;

    // Request decode: bit0 = unsigned, bit1 = remainder, bit2 = word op.
    logic        in_rem, in_w, in_sign;
    logic [63:0] fmt1, fmt2;
    logic        div_zero, sgn_ovf, special;
    logic [63:0] spec_quot, spec_rem;
    logic        accept;
    logic        capture;

    logic        hit;
    logic [63:0] hit_quot, hit_rem;

    function automatic logic [63:0] fmt_src(input logic [63:0] src, input logic w,
                                            input logic sgn);
        logic [63:0] r;
        if (!w)       r = src;
        else if (sgn) r = {{32{src[31]}}, src[31:0]};
        else          r = {32'd0, src[31:0]};
        return r;
    endfunction

    function automatic logic [63:0] fmt_res(input logic [63:0] quot, input logic [63:0] rem,
                                            input logic sel_rem, input logic w);
        logic [63:0] sel;
        sel = sel_rem ? rem : quot;
        return w ? {{32{sel[31]}}, sel[31:0]} : sel;
    endfunction

    assign in_rem  = in_op_i[1];
    assign in_w    = in_op_i[2];
    assign in_sign = ~in_op_i[0];

    assign fmt1 = fmt_src(in_src1_i, in_w, in_sign);
    assign fmt2 = fmt_src(in_src2_i, in_w, in_sign);

    assign div_zero = (fmt2 == 64'd0);
    assign sgn_ovf  = in_sign && (fmt2 == AllOnes) &&
                      (fmt1 == (in_w ? MinNeg32 : MinNeg64));
    assign special  = div_zero || sgn_ovf;

    assign spec_quot = div_zero ? AllOnes : fmt1;
    assign spec_rem  = div_zero ? fmt1 : 64'd0;

    assign in_ready_o = (state_q == StIdle) && !flush_i;
    assign accept     = in_valid_i && (state_q == StIdle) && !flush_i;
    assign capture    = (state_q == StWait) && div_valid_i && !flush_i;

    assign out_data_o      = res_q;
    assign out_tag_o       = tag_q;
    assign div_op_1_o      = op1_q;
    assign div_op_2_o      = op2_q;
    assign div_sign_op_1_o = sign_q;
    assign div_sign_op_2_o = sign_q;

`ifdef DIVCTL_REUSE_EN
    logic        sv_valid_q, sv_valid_d;
    logic [63:0] sv_op1_q, sv_op1_d;
    logic [63:0] sv_op2_q, sv_op2_d;
    logic        sv_sign_q, sv_sign_d;
    logic        sv_w_q, sv_w_d;
    logic [63:0] sv_quot_q, sv_quot_d;
    logic [63:0] sv_rem_q, sv_rem_d;

    assign hit = sv_valid_q && (sv_op1_q == fmt1) && (sv_op2_q == fmt2) &&
                 (sv_sign_q == in_sign) && (sv_w_q == in_w);
    assign hit_quot = sv_quot_q;
    assign hit_rem  = sv_rem_q;

    always_comb begin
        sv_valid_d = sv_valid_q;
        sv_op1_d   = sv_op1_q;
        sv_op2_d   = sv_op2_q;
        sv_sign_d  = sv_sign_q;
        sv_w_d     = sv_w_q;
        sv_quot_d  = sv_quot_q;
        sv_rem_d   = sv_rem_q;
        if (flush_i || (accept && special)) begin
            sv_valid_d = 1'b0;
        end else if (capture) begin
            sv_valid_d = 1'b1;
            sv_op1_d   = op1_q;
            sv_op2_d   = op2_q;
            sv_sign_d  = sign_q;
            sv_w_d     = is_w_q;
            sv_quot_d  = div_quotient_i;
            sv_rem_d   = div_remainder_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sv_valid_q <= 1'b0;
            sv_op1_q   <= 64'd0;
            sv_op2_q   <= 64'd0;
            sv_sign_q  <= 1'b0;
            sv_w_q     <= 1'b0;
            sv_quot_q  <= 64'd0;
            sv_rem_q   <= 64'd0;
        end else begin
            sv_valid_q <= sv_valid_d;
            sv_op1_q   <= sv_op1_d;
            sv_op2_q   <= sv_op2_d;
            sv_sign_q  <= sv_sign_d;
            sv_w_q     <= sv_w_d;
            sv_quot_q  <= sv_quot_d;
            sv_rem_q   <= sv_rem_d;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_quot = 64'd0;
    assign hit_rem  = 64'd0;
`endif

    always_comb begin
        state_d         = state_q;
        is_rem_d        = is_rem_q;
        is_w_d          = is_w_q;
        sign_d          = sign_q;
        tag_d           = tag_q;
        op1_d           = op1_q;
        op2_d           = op2_q;
        res_d           = res_q;
        out_valid_o     = 1'b0;
        div_req_valid_o = 1'b0;
        div_block_o     = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    is_rem_d = in_rem;
                    is_w_d   = in_w;
                    sign_d   = in_sign;
                    tag_d    = in_tag_i;
                    op1_d    = fmt1;
                    op2_d    = fmt2;
                    if (special) begin
                        res_d   = fmt_res(spec_quot, spec_rem, in_rem, in_w);
                        state_d = StResp;
                    end else if (hit) begin
                        res_d   = fmt_res(hit_quot, hit_rem, in_rem, in_w);
                        state_d = StResp;
                    end else begin
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                div_block_o     = 1'b0;
                div_req_valid_o = !flush_i;
                if (flush_i)          state_d = StIdle;
                else if (div_ready_i) state_d = StWait;
            end
            StWait: begin
                div_block_o = 1'b0;
                // A result landing in the flush cycle is dropped; no drain needed then.
                if (div_valid_i) begin
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        res_d   = fmt_res(div_quotient_i, div_remainder_i, is_rem_q, is_w_q);
                        state_d = StResp;
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                out_valid_o = !flush_i;
                if (flush_i || out_ready_i) state_d = StIdle;
            end
            StDrain: begin
                div_block_o = 1'b0;
                if (div_valid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            is_rem_q <= 1'b0;
            is_w_q   <= 1'b0;
            sign_q   <= 1'b0;
            tag_q    <= '0;
            op1_q    <= 64'd0;
            op2_q    <= 64'd0;
            res_q    <= 64'd0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            is_w_q   <= is_w_d;
            sign_q   <= sign_d;
            tag_q    <= tag_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a cycle-accurate model of the 66-state divider.
module tb_div_ctrl;

    localparam logic [2:0] OpDiv   = 3'd0;
    localparam logic [2:0] OpDivu  = 3'd1;
    localparam logic [2:0] OpRem   = 3'd2;
    localparam logic [2:0] OpRemu  = 3'd3;
    localparam logic [2:0] OpDivw  = 3'd4;
    localparam logic [2:0] OpRemw  = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_tag;
    logic        div_req_valid;
    logic        div_block;
    logic [63:0] div_op_1;
    logic [63:0] div_op_2;
    logic        div_sign_1;
    logic        div_sign_2;
    logic [63:0] div_quot;
    logic [63:0] div_rem;
    logic        div_ready;
    logic        div_valid;

    int tests   = 0;
    int fails   = 0;
    int req_cnt = 0;
    int dcnt    = 0;

    always #5 clk = ~clk;

    div_ctrl #(.TAG_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_op_i         (in_op),
        .in_src1_i       (in_src1),
        .in_src2_i       (in_src2),
        .in_tag_i        (in_tag),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_tag_o       (out_tag),
        .div_req_valid_o (div_req_valid),
        .div_block_o     (div_block),
        .div_op_1_o      (div_op_1),
        .div_op_2_o      (div_op_2),
        .div_sign_op_1_o (div_sign_1),
        .div_sign_op_2_o (div_sign_2),
        .div_quotient_i  (div_quot),
        .div_remainder_i (div_rem),
        .div_ready_i     (div_ready),
        .div_valid_i     (div_valid)
    );

    // Divider model: idle (state 0) reports valid; a launch runs states 1..66, valid again at 66.
    assign div_ready = (dcnt == 0);
    assign div_valid = (dcnt == 0) || (dcnt == 66);

    always @(posedge clk) begin
        if (rst) begin
            dcnt     <= 0;
            div_quot <= 64'd0;
            div_rem  <= 64'd0;
        end else if (dcnt == 0) begin
            if (div_req_valid && !div_block) begin
                dcnt <= 1;
                if (div_op_2 == 64'd0) begin
                    div_quot <= 64'hFFFF_FFFF_FFFF_FFFF;
                    div_rem  <= div_op_1;
                end else if (div_sign_1) begin
                    div_quot <= $signed(div_op_1) / $signed(div_op_2);
                    div_rem  <= $signed(div_op_1) % $signed(div_op_2);
                end else begin
                    div_quot <= div_op_1 / div_op_2;
                    div_rem  <= div_op_1 % div_op_2;
                end
            end
        end else if (!div_block) begin
            dcnt <= (dcnt == 66) ? 0 : dcnt + 1;
        end
    end

    always @(posedge clk) begin
        if (div_req_valid) req_cnt <= req_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1 (accept happens in cycle 0).
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag);
        @(negedge clk);
        check("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 150) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tag,
                          input logic [63:0] exp_data, input int exp_lat);
        int lat;
        issue(op, a, b, tag);
        wait_out(lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_data"}, out_data, exp_data);
        check({name, "_tag"}, {60'd0, out_tag}, {60'd0, tag});
        @(negedge clk);
        check({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int lat;
        int req_before;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_src1   = 64'd0;
        in_src2   = 64'd0;
        in_tag    = 4'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_req_valid", {63'd0, div_req_valid}, 64'd0);
        check("rst_block", {63'd0, div_block}, 64'd1);
        check("rst_data", out_data, 64'd0);
        check("rst_tag", {60'd0, out_tag}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_op("div_neg", OpDiv, -64'sd20, 64'd3, 4'd5, 64'hFFFF_FFFF_FFFF_FFFA, 68);
        run_op("remu", OpRemu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 4'd2, 64'd5, 68);
        run_op("remw", OpRemw, 64'h1_8000_0007, 64'd2, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 68);

        req_before = req_cnt;
        run_op("div_zero", OpDiv, 64'd123, 64'd0, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem_zero", OpRem, 64'd77, 64'd0, 4'd7, 64'd77, 1);
        run_op("divw_ovf", OpDivw, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8,
               64'hFFFF_FFFF_8000_0000, 1);
        check("special_no_launch", 64'(req_cnt), 64'(req_before));

        // Flush in WAIT at cycle 30: drain until divider state 66 (cycle 67).
        issue(OpDivu, 64'd1000, 64'd7, 4'd9);
        repeat (29) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        for (int k = 31; k <= 67; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("flush_drain_quiet", 64'(bad), 64'd0);
        check("flush_ready_cycle68", {63'd0, in_ready}, 64'd1);
        check("flush_no_valid", {63'd0, out_valid}, 64'd0);
        run_op("post_flush", OpDivu, 64'd100, 64'd7, 4'd10, 64'd14, 68);

        // Backpressure: hold the result for 10 cycles.
        out_ready = 1'b0;
        issue(OpDiv, -64'sd20, 64'd3, 4'd11);
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'd68);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_FFFF_FFFA ||
                out_tag !== 4'd11 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_still_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_released", {63'd0, out_valid}, 64'd0);
        check("bp_ready_back", {63'd0, in_ready}, 64'd1);

        // Reset in the middle of a divider run.
        issue(OpDivu, 64'd50, 64'd3, 4'd12);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_data", out_data, 64'd0);
        check("midrst_tag", {60'd0, out_tag}, 64'd0);
        check("midrst_block", {63'd0, div_block}, 64'd1);

        run_op("div_100_7", OpDiv, 64'd100, 64'd7, 4'd1, 64'd14, 68);
        req_before = req_cnt;
`ifdef DIVCTL_REUSE_EN
        run_op("rem_reuse", OpRem, 64'd100, 64'd7, 4'd2, 64'd2, 1);
        check("reuse_no_launch", 64'(req_cnt), 64'(req_before));
`else
        run_op("rem_100_7", OpRem, 64'd100, 64'd7, 4'd2, 64'd2, 68);
        check("rem_launched", 64'(req_cnt), 64'(req_before + 1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
